// File: rtl/keypoint_streamer_if.sv
// Byte stream from the keypoint streamer to the serial transmitter.
// One byte moves on each clock edge where tx_valid && tx_ready.
interface keypoint_streamer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/keypoint_streamer.sv
// Streams a keypoint frame (A5, count, 2 bytes per keypoint, 5A) from the keypoint BRAM to a byte transmitter.
// Latency: first byte one cycle after the keypoints_done rising edge; 5 cycles per keypoint with tx_ready high.
// Backpressure: each byte is held stable on tx until tx_ready; tx_ready low stalls indefinitely without loss.
module keypoint_streamer #(
    parameter  int DIMENSION        = 64,
    parameter  int NUMBER_KEYPOINTS = 1000,
    localparam int AW               = $clog2(DIMENSION),
    localparam int KW               = 2*AW + 1,
    localparam int NKW              = $clog2(NUMBER_KEYPOINTS)
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 keypoints_done,
    input  logic [NKW-1:0]       key_count,
    output logic [NKW-1:0]       key_read_addr,
    input  logic [KW-1:0]        key_read_data,
    keypoint_streamer_if.master  tx,
    output logic                 busy,
    output logic                 frame_done
);

    typedef enum logic [3:0] {
        IDLE, HDR, CNT_HI, CNT_LO, FETCH, WAIT1, WAIT2,
        SEND_B0, SEND_B1, TRAILER, DONE
    } state_t;

    state_t          state_q, state_d;
    logic            kd_q;
    logic [15:0]     count_q;
    logic [15:0]     index_q;
    logic [15:0]     index_nxt;
    logic [NKW-1:0]  addr_q;
    logic [KW-1:0]   hold_q;
    logic [15:0]     count_clip;
    logic [15:0]     key_count_ext;
    logic            start;
    logic            accept;
    logic            more;
    logic            tx_vld;
    logic [7:0]      tx_dat;
    logic [5:0]      x6;
    logic [5:0]      y6;

    assign key_count_ext = 16'(key_count);
    assign count_clip    = (key_count_ext > 16'(NUMBER_KEYPOINTS)) ?
                           16'(NUMBER_KEYPOINTS) : key_count_ext;
    assign start         = (state_q == IDLE) && keypoints_done && !kd_q;
    assign accept        = tx_vld && tx.tx_ready;
    assign index_nxt     = index_q + 16'd1;
    assign more          = (index_nxt < count_q);

    assign tx.tx_valid   = tx_vld;
    assign tx.tx_data    = tx_dat;
    assign key_read_addr = addr_q;
    assign busy          = (state_q != IDLE);

    // Coordinates narrower than 6 bits are zero-extended into the byte fields.
    always_comb begin
        x6 = '0;
        y6 = '0;
        x6[AW-1:0] = hold_q[2*AW-1:AW];
        y6[AW-1:0] = hold_q[AW-1:0];
    end

    always_comb begin
        state_d    = state_q;
        tx_vld     = 1'b0;
        tx_dat     = 8'h00;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = HDR;
            end
            HDR: begin
                tx_vld = 1'b1;
                tx_dat = 8'hA5;
                if (accept) state_d = CNT_HI;
            end
            CNT_HI: begin
                tx_vld = 1'b1;
                tx_dat = count_q[15:8];
                if (accept) state_d = CNT_LO;
            end
            CNT_LO: begin
                tx_vld = 1'b1;
                tx_dat = count_q[7:0];
                if (accept) state_d = (count_q != 16'd0) ? FETCH : TRAILER;
            end
            FETCH:   state_d = WAIT1;
            WAIT1:   state_d = WAIT2;
            WAIT2:   state_d = SEND_B0;
            SEND_B0: begin
                tx_vld = 1'b1;
                tx_dat = {1'b1, hold_q[KW-1], x6};
                if (accept) state_d = SEND_B1;
            end
            SEND_B1: begin
                tx_vld = 1'b1;
                tx_dat = {2'b00, y6};
                if (accept) state_d = more ? FETCH : TRAILER;
            end
            TRAILER: begin
                tx_vld = 1'b1;
                tx_dat = 8'h5A;
                if (accept) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The edge register resets high so a level already present at reset release
    // is not mistaken for a new frame request.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            kd_q    <= 1'b1;
            count_q <= '0;
            index_q <= '0;
            addr_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            kd_q    <= keypoints_done;
            if (start) begin
                count_q <= count_clip;
                index_q <= '0;
                addr_q  <= '0;
            end
            // BRAM output is valid during WAIT2: address sampled at the end of
            // FETCH, output register loaded at the end of WAIT1.
            if (state_q == WAIT2) begin
                hold_q <= key_read_data;
            end
            // The address only advances when another keypoint follows, so it
            // keeps the last address read once the frame is finished.
            if (state_q == SEND_B1 && accept) begin
                index_q <= index_nxt;
                if (more) addr_q <= index_nxt[NKW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_keypoint_streamer.sv
// Scoreboard bench: two streamers (64 and 16 pixel sides) against behavioural 2-cycle BRAMs;
// stimulus pushes expected bytes, negedge monitors pop and compare every accepted byte.
module tb_keypoint_streamer;
    localparam int NK  = 1000;
    localparam int NKW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_in;
    logic           kd_a, kd_b;
    logic [NKW-1:0] kc_a, kc_b;
    logic [NKW-1:0] addr_a, addr_b;
    logic [12:0]    rd_a;
    logic [8:0]     rd_b;
    logic           busy_a, busy_b, fd_a, fd_b;

    keypoint_streamer_if ifa ();
    keypoint_streamer_if ifb ();

    keypoint_streamer #(.DIMENSION(64), .NUMBER_KEYPOINTS(NK)) dut_a (
        .clk(clk), .rst_in(rst_in), .keypoints_done(kd_a), .key_count(kc_a),
        .key_read_addr(addr_a), .key_read_data(rd_a), .tx(ifa.master),
        .busy(busy_a), .frame_done(fd_a));

    keypoint_streamer #(.DIMENSION(16), .NUMBER_KEYPOINTS(NK)) dut_b (
        .clk(clk), .rst_in(rst_in), .keypoints_done(kd_b), .key_count(kc_b),
        .key_read_addr(addr_b), .key_read_data(rd_b), .tx(ifb.master),
        .busy(busy_b), .frame_done(fd_b));

    // BRAM models: registered address, registered output.
    logic [12:0]    mem_a [0:1023];
    logic [8:0]     mem_b [0:1023];
    logic [NKW-1:0] aq_a, aq_b;
    always @(posedge clk) begin
        aq_a <= addr_a;
        rd_a <= mem_a[aq_a];
        aq_b <= addr_b;
        rd_b <= mem_b[aq_b];
    end

    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   frames    [2];
    int   bytes     [2];
    bit   exp_fd    [2];
    bit   stall     [2];
    logic [7:0] stall_dat [2];
    bit   rdy_toggle = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic sb_step(input int u, input logic vld, input logic rdy,
                           input logic [7:0] dat, input logic fd);
        logic [7:0] e;
        int         left;
        string      nm;
        nm = (u == 0) ? "a" : "b";
        if (fd || exp_fd[u]) check({"frame_done_", nm}, 32'(fd), 32'(exp_fd[u]));
        if (fd) frames[u]++;
        exp_fd[u] = 1'b0;
        if (stall[u]) begin
            check({"hold_valid_", nm}, 32'(vld), 32'd1);
            check({"hold_data_", nm}, 32'(dat), 32'(stall_dat[u]));
        end
        if (vld && rdy) begin
            bytes[u]++;
            left = (u == 0) ? q_a.size() : q_b.size();
            if (left == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_byte_%s: got %0h, expected no byte", nm, dat);
            end else begin
                if (u == 0) e = q_a.pop_front();
                else        e = q_b.pop_front();
                check({"byte_", nm}, 32'(dat), 32'(e));
                if (e == 8'h5A && left == 1) exp_fd[u] = 1'b1;
            end
        end
        stall[u]     = vld && !rdy;
        stall_dat[u] = dat;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_in) begin
                exp_fd = '{1'b0, 1'b0};
                stall  = '{1'b0, 1'b0};
            end else begin
                sb_step(0, ifa.tx_valid, ifa.tx_ready, ifa.tx_data, fd_a);
                sb_step(1, ifb.tx_valid, ifb.tx_ready, ifb.tx_data, fd_b);
            end
        end
    end

    // Transmitter ready for unit a: tied high, or toggled every 3 cycles.
    initial begin
        int tick;
        tick = 0;
        ifa.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_toggle) begin
                tick++;
                if (tick == 3) begin
                    tick = 0;
                    ifa.tx_ready = ~ifa.tx_ready;
                end
            end else begin
                tick = 0;
                ifa.tx_ready = 1'b1;
            end
        end
    end

    task automatic push(input int u, input logic [7:0] b);
        if (u == 0) q_a.push_back(b);
        else        q_b.push_back(b);
    endtask

    task automatic push_frame_a2();
        logic [7:0] exp_bytes [8];
        exp_bytes = '{8'hA5, 8'h00, 8'h02, 8'hC5, 8'h09, 8'hBF, 8'h00, 8'h5A};
        for (int i = 0; i < 8; i++) push(0, exp_bytes[i]);
    endtask

    task automatic start(input int u, input int kc);
        @(posedge clk);
        #1;
        if (u == 0) begin kc_a = NKW'(kc); kd_a = 1'b0; end
        else        begin kc_b = NKW'(kc); kd_b = 1'b0; end
        @(posedge clk);
        #1;
        if (u == 0) kd_a = 1'b1;
        else        kd_b = 1'b1;
    endtask

    task automatic wait_frame(input int u, input int budget);
        int f0;
        f0 = frames[u];
        for (int i = 0; i < budget && frames[u] == f0; i++) @(posedge clk);
        check(u == 0 ? "frame_timeout_a" : "frame_timeout_b", 32'(frames[u] - f0), 32'd1);
        repeat (3) @(posedge clk);
    endtask

    // Unit b: 16-pixel side, coordinates are 4 bits wide.
    task automatic push_frame_b(input int n);
        logic [15:0] c;
        logic [8:0]  w;
        c = 16'(n);
        push(1, 8'hA5);
        push(1, c[15:8]);
        push(1, c[7:0]);
        for (int i = 0; i < n; i++) begin
            w = mem_b[i];
            push(1, {1'b1, w[8], 2'b00, w[7:4]});
            push(1, {4'h0, w[3:0]});
        end
        push(1, 8'h5A);
    endtask

    initial begin
        int f0, b0;
        rst_in = 1'b0;
        kd_a = 1'b0; kd_b = 1'b0;
        kc_a = '0;   kc_b = '0;
        ifb.tx_ready = 1'b1;
        frames = '{0, 0};
        bytes  = '{0, 0};
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = 9'((i * 37 + 11) % 512);
        end
        mem_a[0] = {1'b1, 6'd5, 6'd9};
        mem_a[1] = {1'b0, 6'd63, 6'd0};
        mem_b[0] = 9'h1A3;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", 32'(ifa.tx_valid), 32'd0);
        check("rst_tx_data", 32'(ifa.tx_data), 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_frame_done", 32'(fd_a), 32'd0);
        check("rst_tx_valid_b", 32'(ifb.tx_valid), 32'd0);
        @(posedge clk);
        #1 rst_in = 1'b1;
        repeat (2) @(posedge clk);

        // Empty frame
        push(0, 8'hA5); push(0, 8'h00); push(0, 8'h00); push(0, 8'h5A);
        start(0, 0);
        wait_frame(0, 100);
        check("idle_busy_after_empty", 32'(busy_a), 32'd0);

        // Two keypoints, ready tied high
        push_frame_a2();
        start(0, 2);
        wait_frame(0, 200);

        // Same frame with ready toggling every 3 cycles
        rdy_toggle = 1'b1;
        push_frame_a2();
        start(0, 2);
        wait_frame(0, 400);
        rdy_toggle = 1'b0;

        // Second rising edge while busy must be ignored
        f0 = frames[0];
        push_frame_a2();
        start(0, 2);
        repeat (3) @(posedge clk);
        #1 kd_a = 1'b0;
        @(posedge clk);
        #1 kd_a = 1'b1;
        wait_frame(0, 200);
        repeat (40) @(posedge clk);
        check("single_frame_on_rebounce", 32'(frames[0] - f0), 32'd1);
        check("busy_after_rebounce", 32'(busy_a), 32'd0);

        // Reset after the 4th byte, then keypoints_done held high across release
        b0 = bytes[0];
        push_frame_a2();
        start(0, 2);
        for (int i = 0; i < 200 && bytes[0] < b0 + 4; i++) begin
            @(negedge clk);
            #1;
        end
        check("bytes_before_abort", 32'(bytes[0] - b0), 32'd4);
        @(posedge clk);
        #1 rst_in = 1'b0;
        q_a.delete();
        repeat (3) @(posedge clk);
        #1 rst_in = 1'b1;
        repeat (30) @(posedge clk);
        check("no_bytes_after_abort", 32'(bytes[0] - b0), 32'd4);
        check("busy_after_abort", 32'(busy_a), 32'd0);
        push_frame_a2();
        start(0, 2);
        wait_frame(0, 200);

        // 999 keypoints on the 16-pixel unit: count 03 E7, first keypoint CA 03
        push_frame_b(NK - 1);
        check("b_first_kp_byte0", 32'(q_b[3]), 32'hCA);
        check("b_count_lo", 32'(q_b[2]), 32'hE7);
        start(1, NK - 1);
        wait_frame(1, 8000);
        check("b_last_addr_999", 32'(addr_b), 32'd998);

        // key_count beyond depth clips to 1000 keypoints
        push_frame_b(NK);
        start(1, 1023);
        wait_frame(1, 8000);
        check("b_last_addr_clip", 32'(addr_b), 32'd999);

        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
